// File: rtl/uart_pkg.sv
// Shared definitions for the AXI-Stream UART transmitter: frame states,
// data width, idle line level and the baud divisor helper.
package uart_pkg;

    localparam int   DATA_BITS       = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rdata always shows the oldest entry.
// full_nxt gives the full flag as it will be after the current edge.
module axis_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic              full_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_nxt;
    logic              wr_en;
    logic              rd_en;

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    always_comb begin
        count_nxt = count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign full_nxt = (count_nxt == CNT_FULL);
    assign rdata    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/axis_uart_tx.sv
// AXI4-Stream slave to UART transmitter: buffers bytes and sends 8N1 frames on dout.
// Define PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module axis_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
    parameter int FIFO_DEPTH   = 16
)(
    input  logic       S_AXIS_ACLK,
    input  logic       S_AXIS_ARESETN,
    input  logic [7:0] S_AXIS_TDATA,
    input  logic       S_AXIS_TVALID,
    output logic       S_AXIS_TREADY,
    input  logic       S_AXIS_TLAST,
    output logic       dout,
    output logic       tx_busy
);

    localparam int                 BCW       = $clog2(CLKS_PER_BIT);
    localparam logic [BCW-1:0]     BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_t            state;
    logic [BCW-1:0]       baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 dout_r;
    logic                 tready_r;
    logic                 fifo_avail_q;
    logic                 baud_tick;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_full_nxt;
    logic [DATA_BITS-1:0] fifo_rdata;
`ifdef PARITY_EN
    logic                 par_r;
`endif

    logic unused_inputs;
    assign unused_inputs = ^{S_AXIS_TLAST, fifo_full};

    axis_sync_fifo #(
        .DATA_W (DATA_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (S_AXIS_ACLK),
        .rst_n    (S_AXIS_ARESETN),
        .push     (fifo_push),
        .wdata    (S_AXIS_TDATA),
        .pop      (fifo_pop),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .full_nxt (fifo_full_nxt)
    );

    assign baud_tick = (baud_cnt == BAUD_LAST);
    assign fifo_push = S_AXIS_TVALID && tready_r;

    // From IDLE the non-empty flag is seen one cycle late, so a fresh beat
    // starts its frame two edges after acceptance; STOP chains frames directly.
    always_comb begin
        fifo_pop = 1'b0;
        if (state == IDLE && fifo_avail_q)
            fifo_pop = 1'b1;
        if (state == STOP && baud_tick && !fifo_empty)
            fifo_pop = 1'b1;
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            dout_r       <= UART_IDLE_LEVEL;
            tready_r     <= 1'b0;
            fifo_avail_q <= 1'b0;
        end else begin
            tready_r     <= !fifo_full_nxt;
            fifo_avail_q <= !fifo_empty;
            baud_cnt     <= baud_tick ? '0 : baud_cnt + 1'b1;
            if (fifo_pop) begin
                state    <= START;
                baud_cnt <= '0;
                dout_r   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        baud_cnt <= '0;
                        dout_r   <= UART_IDLE_LEVEL;
                    end
                    START: begin
                        if (baud_tick) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            dout_r  <= shreg[0];
                        end
                    end
                    DATA: begin
                        if (baud_tick) begin
                            if (bit_cnt == BIT_LAST) begin
`ifdef PARITY_EN
                                state  <= PARITY;
                                dout_r <= par_r;
`else
                                state  <= STOP;
                                dout_r <= UART_IDLE_LEVEL;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                dout_r  <= shreg[1];
                            end
                        end
                    end
`ifdef PARITY_EN
                    PARITY: begin
                        if (baud_tick) begin
                            state  <= STOP;
                            dout_r <= UART_IDLE_LEVEL;
                        end
                    end
`endif
                    STOP: begin
                        if (baud_tick) begin
                            state  <= IDLE;
                            dout_r <= UART_IDLE_LEVEL;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        dout_r <= UART_IDLE_LEVEL;
                    end
                endcase
            end
        end
    end

    // Shift register advances at each bit boundary; dout already holds the next bit.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (fifo_pop) begin
            shreg <= fifo_rdata;
`ifdef PARITY_EN
            par_r <= ^fifo_rdata;
`endif
        end else if (state == DATA && baud_tick) begin
            shreg <= shreg >> 1;
        end
    end

    assign S_AXIS_TREADY = tready_r;
    assign dout          = dout_r;
    assign tx_busy       = (state != IDLE) || !fifo_empty;

endmodule
